hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1: bubble cycles inserted per load-use hazard, legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port de_mem_read  input  1  instruction in DE buffer reads memory.
REQ-006 SHALL have port de_reg_write  input  1  instruction in DE buffer writes a register.
REQ-007 SHALL have port de_write_add  input  3  destination register of the DE instruction.
REQ-008 SHALL have port fd_src1, fd_src2  input  3 each  source registers of the FD-buffer instruction.
REQ-009 SHALL have port fd_src_valid  input  2  bit0 qualifies fd_src1, bit1 qualifies fd_src2.
REQ-010 SHALL have port branch_taken  input  1  branch resolved taken in execute this cycle.
REQ-011 SHALL have port halt_req  input  1  HLT decoded in FD buffer.
REQ-012 SHALL have port resume  input  1  leave HALTED.
REQ-013 SHALL have port pc_write_en  output  1  PC may update.
REQ-014 SHALL have port fd_write_en  output  1  FD buffer may load.
REQ-015 SHALL have port fd_flush, de_flush  output  1 each  load NOP into the FD / DE buffer.
REQ-016 SHALL have port ctrl_state  output  2  RUN=00, STALL=01, HALTED=10.
REQ-017 SHALL have port stall_count  output  CNT_W  cycles with pc_write_en=0.

Function
REQ-018 SHALL compute hazard = de_mem_read & de_reg_write & ((fd_src_valid[0] & fd_src1==de_write_add) | (fd_src_valid[1] & fd_src2==de_write_add)).
REQ-019 SHALL drive outputs combinationally from state and current inputs; state/counter update on the next edge.
REQ-020 RUN, priority branch_taken > hazard > halt_req > normal.
REQ-021 RUN+branch_taken: pc_write_en=1, fd_write_en=1, fd_flush=1, de_flush=1; next RUN.
REQ-022 RUN+hazard: pc_write_en=0, fd_write_en=0, fd_flush=0, de_flush=1; next RUN if STALL_CYCLES==1, else STALL with cnt=STALL_CYCLES-1.
REQ-023 RUN+halt_req: pc_write_en=0, fd_write_en=0, fd_flush=1, de_flush=0; next HALTED.
REQ-024 RUN normal: pc_write_en=1, fd_write_en=1, both flushes 0.
REQ-025 STALL: pc_write_en=0, fd_write_en=0, de_flush=1, fd_flush=0; hazard and halt_req ignored; cnt decrements; cnt==1 -> RUN.
REQ-026 STALL+branch_taken: abort stall, outputs per REQ-021, cnt cleared, next RUN.
REQ-027 HALTED: pc_write_en=0, fd_write_en=0, de_flush=1, fd_flush=0; branch_taken, hazard, halt_req ignored.
REQ-028 HALTED+resume: next RUN; outputs in that cycle remain HALTED values; resume ignored in other states.
REQ-029 ctrl_state SHALL reflect registered state, never the unreachable code 11; 11 SHALL recover to RUN next edge.

Reset
REQ-030 reset high SHALL immediately force state RUN, cnt 0, stall_count 0.
REQ-031 While reset high outputs SHALL be pc_write_en=0, fd_write_en=0, fd_flush=1, de_flush=1, independent of inputs.
REQ-032 reset asserted mid-STALL or in HALTED SHALL discard remaining count/halt; first cycle after release behaves as RUN.

Configuration
REQ-033 With STALL_COUNTER_EN defined, stall_count SHALL increment by 1 each edge where pc_write_en=0 and reset low, saturating at all-ones.
REQ-034 Without STALL_COUNTER_EN, stall_count SHALL be constant 0 and no counter register SHALL be instantiated.

Verification
REQ-035 STALL_CYCLES=1, de_mem_read=1, de_reg_write=1, de_write_add=3, fd_src1=3, fd_src_valid=01 for one cycle -> that cycle pc_write_en=0, fd_write_en=0, de_flush=1; next cycle RUN, enables 1.
REQ-036 STALL_CYCLES=3, same hazard -> pc_write_en=0 for exactly 3 cycles, ctrl_state 00,01,01 then 00; stall_count=3 (macro on).
REQ-037 Hazard and branch_taken same cycle -> fd_flush=1, de_flush=1, pc_write_en=1, no STALL entry; fd_src_valid=00 with matching addresses -> no stall.
REQ-038 halt_req=1 in RUN -> fd_flush=1 that cycle, ctrl_state=10 after; branch_taken=1 held 4 cycles -> no change; resume=1 -> ctrl_state=00 one edge later.
REQ-039 reset pulsed during cycle 2 of a 3-cycle stall -> outputs 0/0/1/1 immediately, ctrl_state=00, stall_count=0, normal operation after release.
REQ-040 CNT_W=4, macro on, 20 halted cycles -> stall_count saturates at 15; macro off -> stall_count stays 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller for a short in-order pipeline. It detects
// load-use hazards between the DE and FD buffers, inserts STALL_CYCLES
// bubbles, flushes on taken branches and parks the pipe on HLT until resume.
// Optional feature macro: STALL_COUNTER_EN adds a saturating counter of
// cycles in which the PC is frozen; without it stall_count is tied to zero.
// The registered FSM state is exposed on ctrl_state (RUN=00, STALL=01,
// HALTED=10).
module hazard_control_unit #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_mem_read,
  input  logic             de_reg_write,
  input  logic [2:0]       de_write_add,
  input  logic [2:0]       fd_src1,
  input  logic [2:0]       fd_src2,
  input  logic [1:0]       fd_src_valid,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write_en,
  output logic             fd_write_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Remaining bubbles after the hazard cycle itself.
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = de_mem_read & de_reg_write &
                  ((fd_src_valid[0] & (fd_src1 == de_write_add)) |
                   (fd_src_valid[1] & (fd_src2 == de_write_add)));

  assign ctrl_state = state_q;

  // Next-state and pipeline-control outputs; reset overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write_en = 1'b1;
    fd_write_en = 1'b1;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;
    if (reset) begin
      pc_write_en = 1'b0;
      fd_write_en = 1'b0;
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      state_d     = ST_RUN;
      cnt_d       = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (hazard) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            de_flush    = 1'b1;
            cnt_d       = STALL_INIT;
            state_d     = (STALL_INIT == 4'd0) ? ST_RUN : ST_STALL;
          end else if (halt_req) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fd_flush    = 1'b1;
            state_d     = ST_HALTED;
          end
        end
        ST_STALL: begin
          if (branch_taken) begin
            // A taken branch squashes the dependent instruction anyway.
            fd_flush = 1'b1;
            de_flush = 1'b1;
            cnt_d    = 4'd0;
            state_d  = ST_RUN;
          end else begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            de_flush    = 1'b1;
            if (cnt_q <= 4'd1) begin
              cnt_d   = 4'd0;
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        ST_HALTED: begin
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          de_flush    = 1'b1;
          if (resume) state_d = ST_RUN;
        end
        default: begin
          // Unreachable encoding: freeze the pipe for one cycle and recover.
          pc_write_en = 1'b0;
          fd_write_en = 1'b0;
          de_flush    = 1'b1;
          cnt_d       = 4'd0;
          state_d     = ST_RUN;
        end
      endcase
    end
  end

  // State and bubble counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Count frozen-PC cycles, saturating at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write_en && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (STALL_CYCLES=3, CNT_W=4).
// A mode/bubble model predicts outputs each cycle; directed literal checks
// pin the model at the interesting points.
module tb_hazard_control_unit;

  localparam int SC = 3;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          de_mem_read = 0, de_reg_write = 0;
  logic [2:0]    de_write_add = 0, fd_src1 = 0, fd_src2 = 0;
  logic [1:0]    fd_src_valid = 0;
  logic          branch_taken = 0, halt_req = 0, resume = 0;
  logic          pc_write_en, fd_write_en, fd_flush, de_flush;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_count;

  hazard_control_unit #(.STALL_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .de_mem_read(de_mem_read), .de_reg_write(de_reg_write),
    .de_write_add(de_write_add), .fd_src1(fd_src1), .fd_src2(fd_src2),
    .fd_src_valid(fd_src_valid), .branch_taken(branch_taken),
    .halt_req(halt_req), .resume(resume),
    .pc_write_en(pc_write_en), .fd_write_en(fd_write_en),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // mode: 0 running, 1 inserting bubbles, 2 halted.
  // bub: bubbles still to be inserted, counting the current stall cycle.
  int m_mode = 0, m_bub = 0, m_cnt = 0;
  int n_mode = 0, n_bub = 0, n_cnt = 0;

  // Compare process: predict outputs from mode + inputs and check every cycle.
  always @(negedge clk) begin : compare_p
    logic e_pc, e_fd, e_ff, e_df, hz;
    if (reset) begin
      m_mode = 0; m_bub = 0; m_cnt = 0;
      {e_pc, e_fd, e_ff, e_df} = 4'b0011;
      n_mode = 0; n_bub = 0; n_cnt = 0;
    end else begin
      hz = de_mem_read && de_reg_write &&
           ((fd_src_valid[0] && fd_src1 == de_write_add) ||
            (fd_src_valid[1] && fd_src2 == de_write_add));
      n_mode = m_mode; n_bub = m_bub;
      {e_pc, e_fd, e_ff, e_df} = 4'b1100;
      if (m_mode == 0) begin
        if (branch_taken) {e_pc, e_fd, e_ff, e_df} = 4'b1111;
        else if (hz) begin
          {e_pc, e_fd, e_ff, e_df} = 4'b0001;
          n_bub = SC - 1;
          n_mode = (n_bub > 0) ? 1 : 0;
        end else if (halt_req) begin
          {e_pc, e_fd, e_ff, e_df} = 4'b0010;
          n_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (branch_taken) begin
          {e_pc, e_fd, e_ff, e_df} = 4'b1111;
          n_mode = 0; n_bub = 0;
        end else begin
          {e_pc, e_fd, e_ff, e_df} = 4'b0001;
          n_bub = m_bub - 1;
          n_mode = (n_bub > 0) ? 1 : 0;
        end
      end else begin
        {e_pc, e_fd, e_ff, e_df} = 4'b0001;
        if (resume) n_mode = 0;
      end
      n_cnt = (!e_pc && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    end
    chk("pc_write_en", 32'(pc_write_en), 32'(e_pc));
    chk("fd_write_en", 32'(fd_write_en), 32'(e_fd));
    chk("fd_flush", 32'(fd_flush), 32'(e_ff));
    chk("de_flush", 32'(de_flush), 32'(e_df));
    chk("ctrl_state", 32'(ctrl_state), 32'(m_mode));
`ifdef STALL_COUNTER_EN
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
`else
    chk("stall_count", 32'(stall_count), 32'd0);
`endif
  end

  // Model state advances on the clock edge.
  always @(posedge clk) begin
    m_mode = n_mode; m_bub = n_bub; m_cnt = n_cnt;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mr, input logic rw, input logic [2:0] wa,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic [1:0] v, input logic br, input logic hr,
                       input logic rs);
    @(posedge clk); #1;
    de_mem_read = mr; de_reg_write = rw; de_write_add = wa;
    fd_src1 = s1; fd_src2 = s2; fd_src_valid = v;
    branch_taken = br; halt_req = hr; resume = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic lit_out(input string nm, input logic [3:0] exp_out, input logic [1:0] exp_st);
    chk({nm, ".outs"}, 32'({pc_write_en, fd_write_en, fd_flush, de_flush}), 32'(exp_out));
    chk({nm, ".state"}, 32'(ctrl_state), 32'(exp_st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sample();
    lit_out("reset", 4'b0011, 2'b00);
    chk("reset.count", 32'(stall_count), 32'd0);
    @(posedge clk); #1 reset = 0;
    sample();
    lit_out("run_idle", 4'b1100, 2'b00);

    // Load-use hazard via src1: three frozen cycles, states 00,01,01, then 00.
    drive(1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 0, 0);
    sample(); lit_out("haz_c0", 4'b0001, 2'b00);
    idle(); sample(); lit_out("haz_c1", 4'b0001, 2'b01);
    idle(); sample(); lit_out("haz_c2", 4'b0001, 2'b01);
    idle(); sample(); lit_out("haz_done", 4'b1100, 2'b00);

    // Hazard with branch in the same cycle: flush both, no stall.
    drive(1, 1, 3'd3, 3'd3, 3'd0, 2'b01, 1, 0, 0);
    sample(); lit_out("haz_br", 4'b1111, 2'b00);
    idle(); sample(); lit_out("haz_br_after", 4'b1100, 2'b00);

    // Matching addresses but unqualified sources: no stall.
    drive(1, 1, 3'd5, 3'd5, 3'd5, 2'b00, 0, 0, 0);
    sample(); lit_out("no_valid", 4'b1100, 2'b00);
    // Not a load: no stall.
    drive(0, 1, 3'd2, 3'd2, 3'd2, 2'b11, 0, 0, 0);
    sample(); lit_out("no_load", 4'b1100, 2'b00);
    // Hazard through src2, then branch aborts the stall.
    drive(1, 1, 3'd6, 3'd1, 3'd6, 2'b10, 0, 0, 0);
    sample(); lit_out("haz_src2", 4'b0001, 2'b00);
    drive(0, 0, 0, 0, 0, 2'b00, 1, 1, 0);
    sample(); lit_out("stall_br", 4'b1111, 2'b01);
    idle(); sample(); lit_out("stall_br_after", 4'b1100, 2'b00);

    // Halt; branch/hazard/halt ignored while halted; resume.
    drive(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    sample(); lit_out("halt_c0", 4'b0010, 2'b00);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 3'd4, 3'd4, 3'd0, 2'b01, 1, 1, 0);
      sample(); lit_out("halted_br", 4'b0001, 2'b10);
    end
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    sample(); lit_out("resume_cyc", 4'b0001, 2'b10);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    sample(); lit_out("resumed", 4'b1100, 2'b00);

    // Reset pulsed during the second cycle of a stall.
    drive(1, 1, 3'd7, 3'd7, 3'd0, 2'b01, 0, 0, 0);
    idle();
    reset = 1;
    sample(); lit_out("rst_mid", 4'b0011, 2'b00);
    chk("rst_mid.count", 32'(stall_count), 32'd0);
    @(posedge clk); #1 reset = 0;
    sample(); lit_out("rst_after", 4'b1100, 2'b00);

    // Long halt: counter saturates when present.
    drive(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    repeat (20) idle();
    sample();
`ifdef STALL_COUNTER_EN
    chk("sat.count", 32'(stall_count), 32'd15);
`else
    chk("sat.count", 32'(stall_count), 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    idle();

    // Mixed vectors with a small register range so hazards are frequent.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)),
            3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) == 0));
    end
    idle();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
